// File: rtl/tape_transport.sv
// Tape transport: position generator with stop/play/ffwd/rew/eot state machine,
// runtime tick divider, seek and optional looping in play mode.
module tape_transport #(
    parameter int unsigned POS_W     = 24,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned FAST_STEP = 8,
    parameter int unsigned DEF_DIV   = 6666
) (
    input  logic             i_clk_sys,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd,
    input  logic [POS_W-1:0] i_seek_pos,
    input  logic [POS_W-1:0] i_tape_end,
    input  logic [DIV_W-1:0] i_div_cfg,
    input  logic             i_loop_en,
    output logic [POS_W-1:0] o_pos,
    output logic [POS_W-1:0] o_max,
    output logic [2:0]       o_state,
    output logic             o_tick,
    output logic             o_ena
);

    typedef enum logic [2:0] {
        StStop = 3'd0,
        StPlay = 3'd1,
        StFfwd = 3'd2,
        StRew  = 3'd3,
        StEot  = 3'd4
    } state_e;

    state_e           r_state;
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] r_max;
    logic [DIV_W-1:0] r_div;
    // Period minus one currently in force; reloaded only at a period start.
    logic [DIV_W-1:0] r_per;
    logic             r_tick;
    logic             r_ena;
    logic             r_cmd_ready;

    logic             w_accept;
    logic             w_moving;
    logic             w_wrap;
    logic [DIV_W-1:0] w_cfg_per;
    logic [POS_W-1:0] w_pos_clamp;
    logic [POS_W-1:0] w_seek_clamp;
    logic [POS_W:0]   w_pos_ext;
    logic [POS_W:0]   w_max_ext;
    logic [POS_W:0]   w_fwd_step;
    logic [POS_W:0]   w_fwd_sum;
    logic             w_fwd_ok;
    logic             w_rew_ok;
    logic [POS_W-1:0] w_tick_pos;
    state_e           w_tick_state;
    logic [POS_W-1:0] w_cmd_pos;
    state_e           w_cmd_state;

    // Divider and position arithmetic, widened by one bit so sums cannot overflow.
    always_comb begin
        w_accept     = i_cmd_valid && r_cmd_ready;
        w_moving     = (r_state == StPlay) || (r_state == StFfwd) || (r_state == StRew);
        w_wrap       = w_moving && (r_div == r_per);
        w_cfg_per    = (i_div_cfg == '0) ? DIV_W'(DEF_DIV) : i_div_cfg;
        w_pos_clamp  = (r_pos > r_max) ? r_max : r_pos;
        w_seek_clamp = (i_seek_pos > r_max) ? r_max : i_seek_pos;
        w_pos_ext    = {1'b0, r_pos};
        w_max_ext    = {1'b0, r_max};
        w_fwd_step   = (r_state == StPlay) ? (POS_W+1)'(1) : (POS_W+1)'(FAST_STEP);
        w_fwd_sum    = w_pos_ext + w_fwd_step;
        w_fwd_ok     = w_fwd_sum < w_max_ext;
        w_rew_ok     = w_pos_ext > (POS_W+1)'(FAST_STEP);
    end

    // Position/state outcome of a divider tick in the current mode.
    always_comb begin
        w_tick_pos   = r_pos;
        w_tick_state = r_state;
        case (r_state)
            StPlay, StFfwd: begin
                if (w_fwd_ok) begin
                    w_tick_pos = w_fwd_sum[POS_W-1:0];
                end else if ((r_state == StPlay) && i_loop_en) begin
                    w_tick_pos = '0;
                end else begin
                    w_tick_pos   = r_max;
                    w_tick_state = StEot;
                end
            end
            StRew: begin
                if (w_rew_ok) begin
                    w_tick_pos = r_pos - POS_W'(FAST_STEP);
                end else begin
                    w_tick_pos   = '0;
                    w_tick_state = StStop;
                end
            end
            default: ;
        endcase
    end

    // Position/state outcome of an accepted command.
    always_comb begin
        w_cmd_pos   = w_pos_clamp;
        w_cmd_state = r_state;
        case (i_cmd)
            3'd0: w_cmd_state = StStop;
            3'd1: w_cmd_state = StPlay;
            3'd2: w_cmd_state = StFfwd;
            3'd3: w_cmd_state = StRew;
            3'd4: begin
                w_cmd_pos = w_seek_clamp;
                if ((r_state == StEot) && (w_seek_clamp < r_max)) begin
                    w_cmd_state = StStop;
                end
            end
            default: ;
        endcase
    end

    // Transport FSM, divider and registered outputs; priority is
    // no-tape > command > shrink clamp > tick > divider count.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state     <= StStop;
            r_pos       <= '0;
            r_max       <= '0;
            r_div       <= '0;
            r_per       <= DIV_W'(DEF_DIV);
            r_tick      <= 1'b0;
            r_ena       <= 1'b0;
            r_cmd_ready <= 1'b0;
        end else begin
            r_max       <= i_tape_end;
            r_ena       <= (i_tape_end != '0);
            r_cmd_ready <= 1'b1;
            r_tick      <= 1'b0;
            if (r_max == '0) begin
                // No tape: commands are swallowed and the transport stays parked.
                r_pos   <= '0;
                r_state <= StStop;
                r_div   <= '0;
                r_per   <= w_cfg_per;
            end else if (w_accept) begin
                r_pos   <= w_cmd_pos;
                r_state <= w_cmd_state;
                r_div   <= '0;
                r_per   <= w_cfg_per;
            end else if (r_pos > r_max) begin
                // Tape shrank under the head; forward motion runs into the end.
                r_pos <= r_max;
                if ((r_state == StPlay) || (r_state == StFfwd)) begin
                    r_state <= StEot;
                end
                r_div <= '0;
                r_per <= w_cfg_per;
            end else if (w_wrap) begin
                r_pos   <= w_tick_pos;
                r_state <= w_tick_state;
                r_tick  <= 1'b1;
                r_div   <= '0;
                r_per   <= w_cfg_per;
            end else if (w_moving) begin
                r_div <= r_div + DIV_W'(1);
            end else begin
                r_div <= '0;
                r_per <= w_cfg_per;
            end
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_pos       = r_pos;
    assign o_max       = r_max;
    assign o_state     = r_state;
    assign o_tick      = r_tick;
    assign o_ena       = r_ena;

endmodule

// File: tb/tb_tape_transport.sv
// Bench for tape_transport: a reference model schedules ticks by absolute cycle
// number and pushes expected outputs into a scoreboard checked by a monitor.
module tb_tape_transport;

    localparam int POS_W  = 24;
    localparam int DIV_W  = 16;
    localparam int FAST   = 8;
    localparam int DEF    = 6666;
    localparam int S_STOP = 0;
    localparam int S_PLAY = 1;
    localparam int S_FFWD = 2;
    localparam int S_REW  = 3;
    localparam int S_EOT  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd;
    logic [POS_W-1:0] seek_pos;
    logic [POS_W-1:0] tape_end;
    logic [DIV_W-1:0] div_cfg;
    logic             loop_en;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] max_o;
    logic [2:0]       state;
    logic             tick;
    logic             ena;

    always #5 clk = ~clk;

    tape_transport #(
        .POS_W    (POS_W),
        .DIV_W    (DIV_W),
        .FAST_STEP(FAST),
        .DEF_DIV  (DEF)
    ) u_dut (
        .i_clk_sys  (clk),
        .i_reset    (rst),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd      (cmd),
        .i_seek_pos (seek_pos),
        .i_tape_end (tape_end),
        .i_div_cfg  (div_cfg),
        .i_loop_en  (loop_en),
        .o_pos      (pos),
        .o_max      (max_o),
        .o_state    (state),
        .o_tick     (tick),
        .o_ena      (ena)
    );

    typedef struct {
        int    at;
        int    pos;
        int    st;
        int    tk;
        int    mx;
        int    en;
        int    rdy;
        string tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   edge_n = 0;

    // Reference model state: next tick is an absolute edge number.
    int m_pos   = 0;
    int m_st    = S_STOP;
    int m_max   = 0;
    int m_next  = 0;
    bit m_ready = 1'b0;

    function automatic int eff_per();
        return ((div_cfg == '0) ? DEF : int'(div_cfg)) + 1;
    endfunction

    function automatic void push(int e, int tk, string tag);
        exp_t x;
        x.at  = e;
        x.pos = m_pos;
        x.st  = m_st;
        x.tk  = tk;
        x.mx  = m_max;
        x.en  = (m_max != 0) ? 1 : 0;
        x.rdy = m_ready ? 1 : 0;
        x.tag = tag;
        sb.push_back(x);
    endfunction

    function automatic void do_cmd();
        if (m_pos > m_max) m_pos = m_max;
        case (int'(cmd))
            0: m_st = S_STOP;
            1: m_st = S_PLAY;
            2: m_st = S_FFWD;
            3: m_st = S_REW;
            4: begin
                m_pos = (int'(seek_pos) > m_max) ? m_max : int'(seek_pos);
                if (m_st == S_EOT && m_pos < m_max) m_st = S_STOP;
            end
            default: ;
        endcase
    endfunction

    function automatic void do_tick();
        case (m_st)
            S_PLAY: begin
                if (m_pos + 1 < m_max) m_pos = m_pos + 1;
                else if (loop_en) m_pos = 0;
                else begin m_pos = m_max; m_st = S_EOT; end
            end
            S_FFWD: begin
                if (m_pos + FAST < m_max) m_pos = m_pos + FAST;
                else begin m_pos = m_max; m_st = S_EOT; end
            end
            S_REW: begin
                if (m_pos > FAST) m_pos = m_pos - FAST;
                else begin m_pos = 0; m_st = S_STOP; end
            end
            default: ;
        endcase
    endfunction

    // Evaluate what edge e does with the inputs currently applied.
    task automatic model_edge(input int e);
        bit    acc;
        bit    mv;
        int    tk;
        string tag;
        tk  = 0;
        tag = "";
        if (rst) begin
            m_pos = 0; m_st = S_STOP; m_max = 0; m_ready = 1'b0;
            push(e, 0, "reset");
            return;
        end
        acc = cmd_valid && m_ready;
        mv  = (m_st == S_PLAY) || (m_st == S_FFWD) || (m_st == S_REW);
        if (m_max == 0) begin
            m_pos = 0; m_st = S_STOP; tag = "notape";
        end else if (acc) begin
            do_cmd(); m_next = e + eff_per(); tag = "cmd";
        end else if (m_pos > m_max) begin
            m_pos = m_max;
            if (m_st == S_PLAY || m_st == S_FFWD) m_st = S_EOT;
            m_next = e + eff_per(); tag = "clamp";
        end else if (mv && e == m_next) begin
            do_tick(); tk = 1; m_next = e + eff_per(); tag = "tick";
        end
        m_ready = 1'b1;
        m_max   = int'(tape_end);
        if (tag != "") push(e, tk, tag);
    endtask

    task automatic step();
        int e;
        e = edge_n + 1;
        model_edge(e);
        @(posedge clk);
        edge_n = e;
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input int c, input int s);
        cmd_valid = 1'b1;
        cmd       = 3'(c);
        seek_pos  = POS_W'(s);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
        steps(2);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Monitor: compare each scheduled expectation; otherwise tick must stay low.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at < edge_n) begin
            mon_x = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expectation for edge %0d never checked", mon_x.tag, mon_x.at);
        end
        if (sb.size() > 0 && sb[0].at == edge_n) begin
            mon_x = sb.pop_front();
            n_cmp++;
            if (pos !== POS_W'(mon_x.pos) || state !== 3'(mon_x.st) || tick !== 1'(mon_x.tk)
                || max_o !== POS_W'(mon_x.mx) || ena !== 1'(mon_x.en)
                || cmd_ready !== 1'(mon_x.rdy)) begin
                n_bad++;
                $display("FAIL %s@%0d: pos %0d/%0d state %0d/%0d tick %0b/%0d max %0d/%0d ena %0b/%0d rdy %0b/%0d (got/required)",
                         mon_x.tag, edge_n, pos, mon_x.pos, state, mon_x.st, tick, mon_x.tk,
                         max_o, mon_x.mx, ena, mon_x.en, cmd_ready, mon_x.rdy);
            end
        end else if (edge_n > 0) begin
            n_cmp++;
            if (tick !== 1'b0) begin
                n_bad++;
                $display("FAIL spurious_tick@%0d: tick %0b, required 0", edge_n, tick);
            end
        end
    end

    initial begin
        int ea;
        int g;
        rst = 1'b1; cmd_valid = 1'b0; cmd = '0; seek_pos = '0;
        tape_end = POS_W'(100); div_cfg = DIV_W'(3); loop_en = 1'b0;

        // 1: play to end of tape
        do_reset();
        chk("t1_ready", int'(cmd_ready), 1);
        chk("t1_max", int'(max_o), 100);
        chk("t1_ena", int'(ena), 1);
        send(1, 0);
        chk("t1_state_after_play", int'(state), S_PLAY);
        steps(3);
        chk("t1_no_early_tick", int'(tick), 0);
        step();
        chk("t1_first_tick", int'(tick), 1);
        chk("t1_first_pos", int'(pos), 1);
        steps(99 * 4 + 12);
        chk("t1_end_pos", int'(pos), 100);
        chk("t1_end_state", int'(state), S_EOT);

        // 2: looping play
        loop_en = 1'b1;
        do_reset();
        send(1, 0);
        steps(400);
        chk("t2_wrap_pos", int'(pos), 0);
        chk("t2_wrap_state", int'(state), S_PLAY);
        chk("t2_wrap_tick", int'(tick), 1);
        steps(8);
        chk("t2_after_wrap", int'(pos), 2);
        loop_en = 1'b0;

        // 3: fast forward then rewind
        do_reset();
        send(4, 50);
        send(2, 0);
        steps(28);
        chk("t3_ffwd_pos", int'(pos), 100);
        chk("t3_ffwd_state", int'(state), S_EOT);
        send(3, 0);
        steps(52);
        chk("t3_rew_pos", int'(pos), 0);
        chk("t3_rew_state", int'(state), S_STOP);

        // 4: seek beyond end, then seek coincident with a tick
        do_reset();
        send(4, 20);
        send(1, 0);
        steps(2);
        send(4, 500);
        chk("t4_seek_clamp", int'(pos), 100);
        chk("t4_seek_state", int'(state), S_PLAY);
        steps(4);
        chk("t4_eot", int'(state), S_EOT);
        send(1, 0);
        send(4, 30);
        for (int i = 0; i < 10 && edge_n + 1 != m_next; i++) step();
        send(4, 60);
        chk("t4_coincident_tick", int'(tick), 0);
        chk("t4_coincident_pos", int'(pos), 60);

        // 5: no tape, then reset mid fast-forward
        tape_end = '0;
        do_reset();
        send(1, 0);
        steps(20);
        chk("t5_ena", int'(ena), 0);
        chk("t5_state", int'(state), S_STOP);
        tape_end = POS_W'(100);
        steps(2);
        send(4, 40);
        send(2, 0);
        steps(2);
        rst = 1'b1;
        step();
        chk("t5_rst_pos", int'(pos), 0);
        chk("t5_rst_ready", int'(cmd_ready), 0);
        rst = 1'b0;
        steps(2);

        // 6: default divider, then change divider mid-period
        tape_end = POS_W'(1000);
        div_cfg  = '0;
        do_reset();
        send(1, 0);
        ea = edge_n;
        steps(3000);
        div_cfg = DIV_W'(1);
        for (int i = 0; i < 4000 && tick !== 1'b1; i++) step();
        chk("t6_default_period", edge_n - ea, DEF + 1);
        step();
        chk("t6_new_gap", int'(tick), 0);
        step();
        chk("t6_new_period", int'(tick), 1);
        chk("t6_new_pos", int'(pos), 2);

        // Randomised command traffic against the model
        tape_end = POS_W'(200);
        div_cfg  = DIV_W'(3);
        do_reset();
        for (int i = 0; i < 80; i++) begin
            g = int'($urandom_range(0, 30));
            steps(g);
            if ($urandom_range(0, 9) == 0) div_cfg = DIV_W'($urandom_range(1, 4));
            if ($urandom_range(0, 14) == 0) tape_end = POS_W'($urandom_range(40, 250));
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, 300)));
        end
        steps(40);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
